fetch_prefetch: RTL and testbench
=================================

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameters SHALL be:
- NB_INST, 32: instruction width.
- NB_ADDR, `ADDRWIDTH: PC and imem address width.
- IMEM_DEPTH, `N_ELEMENTS: instruction memory words.
- FIFO_DEPTH, 4: prefetch queue entries, power of 2, at least 2.
- NOP_WORD, 32'hF8000000: bubble instruction.

REQ-002 Ports SHALL be (clock and reset first):
- i_clk  in  1  single clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_halt  in  1  stop issuing new fetches; queue still drains.
- i_debug_mode  in  1  debug unit owns imem; fetch frozen.
- i_debug_wr_en  in  1  imem write strobe, honoured only in debug mode.
- i_debug_addr  in  NB_ADDR  imem write address.
- i_debug_data  in  NB_INST  imem write data.
- i_redirect  in  1  taken jump or branch; load new PC and flush.
- i_pc_src  in  2  redirect source: 00 register, 01 branch, 10 jump, 11 reserved (treated as 00).
- i_addr_register, i_addr_branch, i_addr_jump  in  NB_ADDR each  redirect targets.
- i_ready  in  1  decode accepts the head entry.
- o_valid  out  1  head entry valid.
- o_instruction  out  NB_INST  head instruction; NOP_WORD when o_valid=0.
- o_pc  out  NB_ADDR  PC of the head instruction.
- o_next_pc  out  NB_ADDR  o_pc+1.
- o_fetch_pc  out  NB_ADDR  PC of the next fetch to issue.
- o_full  out  1  queue full.
- o_empty  out  1  queue empty.

Function
REQ-003 The PC SHALL be word-indexed and advance by 1 per issued fetch; the imem index SHALL be PC modulo IMEM_DEPTH; the PC SHALL wrap from 2^NB_ADDR-1 to 0.

REQ-004 The imem SHALL be a synchronous single-port RAM. Read data SHALL be available 1 cycle after the address is issued; the debug write SHALL take effect on the clock edge at which it is sampled.

REQ-005 A fetch SHALL issue in a cycle only when all of the following hold:
- i_halt=0, i_debug_mode=0 and i_redirect=0;
- (queue count + in-flight count) < FIFO_DEPTH.
At most 1 fetch SHALL be in flight.

REQ-006 Returning read data SHALL be pushed into the queue together with its PC, in the cycle after issue.

REQ-007 A pop SHALL occur when o_valid=1 and i_ready=1. A push and a pop in the same cycle SHALL leave the count unchanged.

REQ-008 o_instruction, o_pc and o_next_pc SHALL be combinational reads of the queue head; they SHALL hold steady while o_valid=1 and i_ready=0.

REQ-009 When i_redirect=1, on that edge:
- PC SHALL load the target selected by i_pc_src;
- the queue SHALL be emptied;
- any in-flight read SHALL be discarded (epoch tag), never pushed;
- no pop SHALL be counted.
The first fetch at the new target SHALL issue the following cycle.

REQ-010 When i_debug_mode=1:
- the queue SHALL flush and in-flight data SHALL be discarded;
- PC SHALL hold unless i_redirect=1;
- o_valid SHALL be 0.

REQ-011 Priority SHALL be reset > redirect > debug_mode > halt > normal fetch.

REQ-012 o_full SHALL equal (count==FIFO_DEPTH) and o_empty SHALL equal (count==0). The queue pointers SHALL wrap modulo FIFO_DEPTH.

REQ-013 Steady-state throughput with i_ready=1 SHALL be 1 instruction per cycle after a 2-cycle start-up latency from reset release or redirect.

Reset
REQ-014 While i_reset=0, regardless of clock:
- PC=0, queue empty, in-flight flag 0, epoch 0;
- o_valid=0, o_instruction=NOP_WORD, o_pc=0, o_next_pc=1;
- o_fetch_pc=0, o_empty=1, o_full=0.

REQ-015 Imem contents SHALL NOT be cleared by reset.

REQ-016 Reset asserted mid-fetch SHALL discard the in-flight read. The first fetch SHALL issue on the first edge after release.

Verification
REQ-017 Load and stream: in debug mode write imem[0..7]=0x1000_0000+i, then leave debug mode with i_ready=1. Required: o_valid rises on the 2nd edge; o_instruction=0x1000_0000..7 on consecutive cycles with o_pc=0..7.

REQ-018 Backpressure: set i_ready=0 for 10 cycles. Required: o_full=1 after FIFO_DEPTH pushes; o_fetch_pc stops at FIFO_DEPTH; the head holds 0x1000_0000. Releasing i_ready SHALL drain in order with no loss or duplication.

REQ-019 Redirect flush: with the queue holding PCs 2..5, pulse i_redirect with i_pc_src=01 and i_addr_branch=0x40. Required: o_valid=0 the next cycle; the next valid o_pc=0x40; PCs 2..5 and the discarded in-flight word never appear.

REQ-020 Source select and simultaneous events: apply redirects with i_pc_src=00, 10 and 11 to targets 0x10 and 0x20. Required: loads 0x10, 0x20 and 0x10 respectively. Asserting i_redirect together with i_halt=1 SHALL still load the target and issue no fetch.

REQ-021 Wrap and reset: with NB_ADDR=4, run from PC=14 to check the wrap 15->0; also assert i_reset=0 mid-stream. Required: outputs match REQ-014 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_prefetch_if.sv
// Decode-side handshake of the prefetcher: head entry offered by the fetch
// unit (master), accepted by decode (slave).
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif

interface fetch_prefetch_if #(
  parameter int NB_INST = 32,
  parameter int NB_ADDR = `ADDRWIDTH
);
  logic               o_valid;
  logic               i_ready;
  logic [NB_INST-1:0] o_instruction;
  logic [NB_ADDR-1:0] o_pc;
  logic [NB_ADDR-1:0] o_next_pc;

  modport master (
    output o_valid, o_instruction, o_pc, o_next_pc,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_instruction, o_pc, o_next_pc,
    output i_ready
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: synchronous imem, one fetch in flight, small queue
// towards decode, redirect/debug flush with epoch-tagged in-flight reads.
`ifndef ADDRWIDTH
`define ADDRWIDTH 8
`endif
`ifndef N_ELEMENTS
`define N_ELEMENTS 16
`endif

module fetch_prefetch #(
  parameter int               NB_INST    = 32,
  parameter int               NB_ADDR    = `ADDRWIDTH,
  parameter int               IMEM_DEPTH = `N_ELEMENTS,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [NB_INST-1:0] NOP_WORD = 32'hF8000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_debug_mode,
  input  logic               i_debug_wr_en,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  input  logic [NB_INST-1:0] i_debug_data,
  input  logic               i_redirect,
  input  logic [1:0]         i_pc_src,
  input  logic [NB_ADDR-1:0] i_addr_register,
  input  logic [NB_ADDR-1:0] i_addr_branch,
  input  logic [NB_ADDR-1:0] i_addr_jump,
  fetch_prefetch_if.master   bus,
  output logic [NB_ADDR-1:0] o_fetch_pc,
  output logic               o_full,
  output logic               o_empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [NB_INST-1:0] r_mem [IMEM_DEPTH];
  logic [NB_INST-1:0] r_rdata;
  logic [NB_ADDR-1:0] r_pc;
  logic               r_inflight;
  logic [NB_ADDR-1:0] r_inflight_pc;
  logic               r_inflight_epoch;
  logic               r_epoch;
  logic [NB_INST-1:0] r_q_inst [FIFO_DEPTH];
  logic [NB_ADDR-1:0] r_q_pc   [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW:0]        r_count;

  logic               w_empty;
  logic               w_full;
  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [PW+1:0]      w_level;
  logic [NB_ADDR-1:0] w_target;
  logic [NB_ADDR-1:0] w_head_pc;
  logic [IW-1:0]      w_rd_idx;
  logic [IW-1:0]      w_wr_idx;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (PW+1)'(FIFO_DEPTH));
  // Debug mode hides the head immediately, before the flush edge lands.
  assign w_valid  = !w_empty && !i_debug_mode;
  assign w_pop    = w_valid && bus.i_ready && !i_redirect;
  // A read that returns on a flush edge, or from an older epoch, is dropped.
  assign w_push   = r_inflight && (r_inflight_epoch == r_epoch) && !i_redirect && !i_debug_mode;
  // Reserve a slot for the read in flight so a returning word always fits.
  assign w_level  = (PW+2)'(r_count) + (PW+2)'(r_inflight);
  assign w_issue  = !i_halt && !i_debug_mode && !i_redirect &&
                    (w_level < (PW+2)'(FIFO_DEPTH));
  assign w_rd_idx = IW'(32'(r_pc) % 32'(IMEM_DEPTH));
  assign w_wr_idx = IW'(32'(i_debug_addr) % 32'(IMEM_DEPTH));

  // Redirect target select; the reserved encoding falls back to the register source.
  always_comb begin
    w_target = i_addr_register;
    case (i_pc_src)
      2'b01:   w_target = i_addr_branch;
      2'b10:   w_target = i_addr_jump;
      default: w_target = i_addr_register;
    endcase
  end

  // Single-port imem: debug writes and fetch reads are mutually exclusive by mode.
  always_ff @(posedge i_clk) begin
    if (i_debug_mode && i_debug_wr_en) r_mem[w_wr_idx] <= i_debug_data;
    if (w_issue) r_rdata <= r_mem[w_rd_idx];
  end

  // Queue storage; only the pointers and count need reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= r_rdata;
      r_q_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  // PC, in-flight tracking, epoch and queue bookkeeping.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc             <= '0;
      r_inflight       <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_epoch <= 1'b0;
      r_epoch          <= 1'b0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc    <= r_pc;
        r_inflight_epoch <= r_epoch;
      end
      if (i_redirect || i_debug_mode) begin
        r_epoch  <= ~r_epoch;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        if (i_redirect) r_pc <= w_target;
      end else begin
        if (w_issue) r_pc     <= r_pc + NB_ADDR'(1);
        if (w_push)  r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (PW+1)'(1);
          2'b01:   r_count <= r_count - (PW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign w_head_pc         = w_valid ? r_q_pc[r_rd_ptr] : '0;
  assign bus.o_valid       = w_valid;
  assign bus.o_instruction = w_valid ? r_q_inst[r_rd_ptr] : NOP_WORD;
  assign bus.o_pc          = w_head_pc;
  assign bus.o_next_pc     = w_head_pc + NB_ADDR'(1);
  assign o_fetch_pc        = r_pc;
  assign o_full            = w_full;
  assign o_empty           = w_empty;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: cycle-exact vector table for start-up and
// backpressure, directed redirect/debug/reset/wrap sequences, and a random
// run checked against the sequential-PC rule of the instruction stream.
module tb_fetch_prefetch;

  localparam logic [31:0] NOP  = 32'hF8000000;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] WB   = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // main instance: NB_ADDR=8, 16-word imem
  logic       halt, dbg, dbg_we, redir;
  logic [7:0] dbg_addr, a_reg, a_br, a_jmp;
  logic [31:0] dbg_data;
  logic [1:0] src;
  logic [7:0] fetch_pc;
  logic       full, empty;
  fetch_prefetch_if #(.NB_INST(32), .NB_ADDR(8)) bus8();

  fetch_prefetch #(.NB_ADDR(8), .IMEM_DEPTH(16)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_halt(halt), .i_debug_mode(dbg),
    .i_debug_wr_en(dbg_we), .i_debug_addr(dbg_addr), .i_debug_data(dbg_data),
    .i_redirect(redir), .i_pc_src(src), .i_addr_register(a_reg),
    .i_addr_branch(a_br), .i_addr_jump(a_jmp), .bus(bus8),
    .o_fetch_pc(fetch_pc), .o_full(full), .o_empty(empty));

  // wrap instance: NB_ADDR=4
  logic       w4_dbg, w4_we, w4_redir;
  logic [3:0] w4_addr, w4_reg, w4_fetch;
  logic [31:0] w4_data;
  logic       w4_full, w4_empty;
  fetch_prefetch_if #(.NB_INST(32), .NB_ADDR(4)) bus4();

  fetch_prefetch #(.NB_ADDR(4), .IMEM_DEPTH(16)) u_w4 (
    .i_clk(clk), .i_reset(rst_n), .i_halt(1'b0), .i_debug_mode(w4_dbg),
    .i_debug_wr_en(w4_we), .i_debug_addr(w4_addr), .i_debug_data(w4_data),
    .i_redirect(w4_redir), .i_pc_src(2'b00), .i_addr_register(w4_reg),
    .i_addr_branch(4'd0), .i_addr_jump(4'd0), .bus(bus4),
    .o_fetch_pc(w4_fetch), .o_full(w4_full), .o_empty(w4_empty));

  int n_cmp = 0;
  int n_bad = 0;

  logic       s_valid, s_full, s_empty;
  logic [31:0] s_inst;
  logic [7:0] s_pc, s_next, s_fetch;
  logic       t_valid;
  logic [31:0] t_inst;
  logic [3:0] t_pc, t_next, t_fetch;

  typedef struct {
    logic       ready;
    logic       valid;
    logic [7:0] pc;
    logic [7:0] fpc;
    logic       full;
    logic       empty;
  } vec_t;
  vec_t vecs[26];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // sample just before the edge (inputs set at the previous negedge), then clock once
  task automatic cycle();
    #1;
    s_valid = bus8.o_valid;  s_inst = bus8.o_instruction; s_pc = bus8.o_pc;
    s_next  = bus8.o_next_pc; s_fetch = fetch_pc; s_full = full; s_empty = empty;
    t_valid = bus4.o_valid;  t_inst = bus4.o_instruction; t_pc = bus4.o_pc;
    t_next  = bus4.o_next_pc; t_fetch = w4_fetch;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus8.i_ready = vecs[i].ready;
      cycle();
      check($sformatf("vec%0d valid", i), s_valid, vecs[i].valid);
      if (vecs[i].valid) begin
        check($sformatf("vec%0d pc", i), s_pc, vecs[i].pc);
        check($sformatf("vec%0d inst", i), s_inst, BASE + 32'(vecs[i].pc % 16));
      end else begin
        check($sformatf("vec%0d nop", i), s_inst, NOP);
      end
      check($sformatf("vec%0d fetch_pc", i), s_fetch, vecs[i].fpc);
      check($sformatf("vec%0d full", i), s_full, vecs[i].full);
      check($sformatf("vec%0d empty", i), s_empty, vecs[i].empty);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"},    bus8.o_valid, 1'b0);
    check({tag, " inst"},     bus8.o_instruction, NOP);
    check({tag, " pc"},       bus8.o_pc, 8'd0);
    check({tag, " next_pc"},  bus8.o_next_pc, 8'd1);
    check({tag, " fetch_pc"}, fetch_pc, 8'd0);
    check({tag, " empty"},    empty, 1'b1);
    check({tag, " full"},     full, 1'b0);
  endtask

  // redirect during streaming (ready=1); target must appear after two bubbles
  task automatic redirect_chk(input logic [1:0] sel, input logic [7:0] tgt);
    src = sel; redir = 1'b1;
    cycle();
    redir = 1'b0;
    cycle();
    check($sformatf("redir src%0d fetch_pc", sel), s_fetch, tgt);
    check($sformatf("redir src%0d bubble1", sel), s_valid, 1'b0);
    cycle();
    check($sformatf("redir src%0d bubble2", sel), s_valid, 1'b0);
    cycle();
    check($sformatf("redir src%0d valid", sel), s_valid, 1'b1);
    check($sformatf("redir src%0d pc", sel), s_pc, tgt);
    check($sformatf("redir src%0d inst", sel), s_inst, BASE + 32'(tgt % 16));
    cycle();
    check($sformatf("redir src%0d pc+1", sel), s_pc, 8'(tgt + 8'd1));
  endtask

  initial begin
    logic [7:0] exp_pc;
    logic [7:0] tgt;
    int pops;
    logic rp [8];

    // stream after debug load: two bubbles, then pc 0..7
    vecs[0] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1};
    for (int i = 2; i < 10; i++) vecs[i] = '{1'b1, 1'b1, 8'(i - 2), 8'(i), 1'b0, 1'b0};
    // backpressure from reset release: fill to 4, hold head 0, then drain
    vecs[10] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 8'd0, 8'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'd0, 8'd4, 1'b0, 1'b0};
    for (int i = 15; i < 20; i++) vecs[i] = '{1'b0, 1'b1, 8'd0, 8'd4, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 8'd0, 8'd4, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 8'd1, 8'd4, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 8'd2, 8'd5, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 8'd3, 8'd6, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 8'd4, 8'd7, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 1'b1, 8'd5, 8'd8, 1'b0, 1'b0};

    halt = 0; dbg = 0; dbg_we = 0; dbg_addr = 0; dbg_data = 0; redir = 0; src = 0;
    a_reg = 8'h10; a_br = 8'h40; a_jmp = 8'h20; bus8.i_ready = 0;
    w4_dbg = 1; w4_we = 0; w4_redir = 0; w4_addr = 0; w4_reg = 0; w4_data = 0; bus4.i_ready = 0;

    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 check_reset_outputs("por");

    // load both imems in debug mode
    dbg = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dbg_we = 1'b1; dbg_addr = 8'(i); dbg_data = BASE + 32'(i);
      w4_we  = 1'b1; w4_addr  = 4'(i); w4_data  = WB + 32'(i);
      cycle();
      check("debug valid", s_valid, 1'b0);
    end
    dbg_we = 1'b0; w4_we = 1'b0; dbg = 1'b0;
    check("debug fetch_pc held", fetch_pc, 8'd0);

    run_vecs(0, 9);

    // asynchronous reset mid-stream, observed between edges
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_vecs(10, 25);

    // redirect flush with the queue holding PCs 2..5
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      bus8.i_ready = rp[k];
      cycle();
      if (k == 2) check("pre-flush pop0", s_pc, 8'd0);
      if (k == 3) check("pre-flush pop1", s_pc, 8'd1);
    end
    bus8.i_ready = 1'b0; src = 2'b01; a_br = 8'h40; redir = 1'b1;
    cycle();
    check("flush full before", s_full, 1'b1);
    check("flush head before", s_pc, 8'd2);
    redir = 1'b0; bus8.i_ready = 1'b1;
    cycle();
    check("flush valid", s_valid, 1'b0);
    check("flush empty", s_empty, 1'b1);
    check("flush fetch_pc", s_fetch, 8'h40);
    cycle();
    check("flush bubble", s_valid, 1'b0);
    for (int j = 0; j < 4; j++) begin
      cycle();
      check($sformatf("post-flush valid%0d", j), s_valid, 1'b1);
      check($sformatf("post-flush pc%0d", j), s_pc, 8'(8'h40 + j));
      check($sformatf("post-flush inst%0d", j), s_inst, BASE + 32'(j));
    end

    // source select
    a_reg = 8'h10; a_jmp = 8'h20; a_br = 8'h77;
    redirect_chk(2'b00, 8'h10);
    redirect_chk(2'b10, 8'h20);
    redirect_chk(2'b11, 8'h10);

    // redirect together with halt: target loads, nothing fetched
    a_br = 8'h33; src = 2'b01; redir = 1'b1; halt = 1'b1;
    cycle();
    redir = 1'b0;
    cycle();
    check("redir+halt fetch_pc", s_fetch, 8'h33);
    check("redir+halt valid", s_valid, 1'b0);
    cycle();
    cycle();
    check("halt no fetch", s_fetch, 8'h33);
    check("halt empty", s_empty, 1'b1);

    // debug mode flushes and freezes PC
    halt = 1'b0; bus8.i_ready = 1'b0;
    repeat (4) cycle();
    dbg = 1'b1;
    cycle();
    check("dbg valid low", s_valid, 1'b0);
    check("dbg nop", s_inst, NOP);
    check("dbg fetch_pc", s_fetch, 8'h37);
    cycle();
    check("dbg flushed", s_empty, 1'b1);
    check("dbg pc held", s_fetch, 8'h37);
    dbg = 1'b0; bus8.i_ready = 1'b1;
    cycle();
    cycle();
    check("dbg exit bubble", s_valid, 1'b0);
    cycle();
    check("dbg exit valid", s_valid, 1'b1);
    check("dbg exit pc", s_pc, 8'h37);
    check("dbg exit inst", s_inst, BASE + 32'd7);

    // PC wrap 15 -> 0 on the 4-bit instance (redirect wins over debug mode)
    w4_reg = 4'd14; w4_redir = 1'b1;
    cycle();
    w4_redir = 1'b0; w4_dbg = 1'b0; bus4.i_ready = 1'b1;
    cycle();
    check("wrap fetch_pc", t_fetch, 4'd14);
    cycle();
    for (int j = 0; j < 4; j++) begin
      tgt = 8'((14 + j) % 16);
      cycle();
      check($sformatf("wrap valid%0d", j), t_valid, 1'b1);
      check($sformatf("wrap pc%0d", j), t_pc, 4'(tgt));
      check($sformatf("wrap next%0d", j), t_next, 4'((tgt + 1) % 16));
      check($sformatf("wrap inst%0d", j), t_inst, WB + 32'(tgt));
    end

    // random traffic: accepted stream must be consecutive PCs from the last target
    src = 2'b00; a_reg = 8'h00; redir = 1'b1;
    cycle();
    redir = 1'b0;
    exp_pc = 8'h00;
    pops = 0;
    for (int n = 0; n < 600; n++) begin
      bus8.i_ready = ($urandom_range(0, 3) != 0);
      halt  = ($urandom_range(0, 7) == 0);
      redir = ($urandom_range(0, 19) == 0);
      src   = 2'($urandom_range(0, 3));
      a_reg = 8'($urandom); a_br = 8'($urandom); a_jmp = 8'($urandom);
      cycle();
      if (redir) begin
        exp_pc = (src == 2'b01) ? a_br : (src == 2'b10) ? a_jmp : a_reg;
      end else if (s_valid) begin
        check("rand head pc", s_pc, exp_pc);
        check("rand head inst", s_inst, BASE + 32'(exp_pc % 16));
        if (bus8.i_ready) begin
          exp_pc = exp_pc + 8'd1;
          pops++;
        end
      end
    end
    check("rand throughput", (pops >= 200), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
